// File: rtl/icache_tag_array.sv
// icache_tag_array: N-way set-associative I-cache tag store with round-robin victim pointers
// and a hardware invalidate-all walker. Optional tag parity enabled by ICACHE_TAG_PARITY_EN.
module icache_tag_array #(
   parameter  int NWAYS   = 2,
   parameter  int SETS_AW = 8,
   parameter  int TAG_W   = 21,
   localparam int WAY_W   = (NWAYS > 1) ? $clog2(NWAYS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [SETS_AW-1:0] req_index,
   input  logic [TAG_W-1:0]   req_tag,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [WAY_W-1:0]   rsp_way,
   output logic [WAY_W-1:0]   rsp_victim,
   input  logic               fill_en,
   input  logic [SETS_AW-1:0] fill_index,
   input  logic [TAG_W-1:0]   fill_tag,
   input  logic [WAY_W-1:0]   fill_way,
   input  logic               inv_req,
   output logic               busy,
   output logic               parity_err
);

   localparam int SETS = 2**SETS_AW;
`ifdef ICACHE_TAG_PARITY_EN
   localparam int ENT_W = TAG_W + 2;
`else
   localparam int ENT_W = TAG_W + 1;
`endif

   // Entry layout: {[parity,] valid, tag}; parity is even over {valid, tag}.
   function automatic logic [ENT_W-1:0] make_entry(input logic [TAG_W-1:0] tag);
`ifdef ICACHE_TAG_PARITY_EN
      return {^{1'b1, tag}, 1'b1, tag};
`else
      return {1'b1, tag};
`endif
   endfunction

   function automatic logic [WAY_W-1:0] next_ptr(input logic [WAY_W-1:0] way);
      if (NWAYS == 1) return '0;
      return way + WAY_W'(1);
   endfunction

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t             state, state_nxt;
   logic [SETS_AW-1:0] cnt, cnt_nxt;
   logic               clearing;
   logic               accept_p0;
   logic               fill_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clearing  = 1'b0;
      case (state)
         ST_CLEAR: begin
            clearing = 1'b1;
            cnt_nxt  = cnt + SETS_AW'(1);
            if (&cnt) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (inv_req) begin
               state_nxt = ST_CLEAR;
               cnt_nxt   = '0;
            end
         end
      endcase
   end

   assign busy      = clearing;
   assign req_ready = ~clearing;
   assign accept_p0 = req_valid & req_ready;
   assign fill_p0   = fill_en & ~clearing;

   // ---- stage p0 -> p1: registered RAM read, pointer and request capture ----
   logic [ENT_W-1:0] rd_ent_p1 [NWAYS];
   logic [WAY_W-1:0] ptr [SETS];
   logic [WAY_W-1:0] ptr_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             vld_p1;

   for (genvar w = 0; w < NWAYS; w++) begin : g_way
      logic [ENT_W-1:0] mem [SETS];
      logic [ENT_W-1:0] ent_p1;

      // Read-before-write: a same-cycle lookup sees the pre-fill entry.
      always_ff @(posedge clk) begin
         if (clearing)
            mem[cnt] <= '0;
         else if (fill_p0 && fill_way == WAY_W'(w))
            mem[fill_index] <= make_entry(fill_tag);
         ent_p1 <= mem[req_index];
      end

      assign rd_ent_p1[w] = ent_p1;
   end

   always_ff @(posedge clk) begin
      if (clearing)
         ptr[cnt] <= '0;
      else if (fill_p0)
         ptr[fill_index] <= next_ptr(fill_way);
      ptr_p1 <= ptr[req_index];
      tag_p1 <= req_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= accept_p0;
   end

   // ---- stage p1: compare, victim select, response ----
   logic [NWAYS-1:0] par_bad_p1;
   logic             hit_p1;
   logic             inv_any_p1;
   logic [WAY_W-1:0] hit_way_p1;
   logic [WAY_W-1:0] inv_way_p1;

   always_comb begin
      for (int w = 0; w < NWAYS; w++) begin
`ifdef ICACHE_TAG_PARITY_EN
         par_bad_p1[w] = ^rd_ent_p1[w];
`else
         par_bad_p1[w] = 1'b0;
`endif
      end
   end

   // Downward scan so the lowest matching / lowest invalid way wins.
   always_comb begin
      hit_p1     = 1'b0;
      hit_way_p1 = '0;
      inv_any_p1 = 1'b0;
      inv_way_p1 = '0;
      for (int w = NWAYS - 1; w >= 0; w--) begin
         if (!par_bad_p1[w] && rd_ent_p1[w][TAG_W] && rd_ent_p1[w][TAG_W-1:0] == tag_p1) begin
            hit_p1     = 1'b1;
            hit_way_p1 = WAY_W'(w);
         end
         if (!rd_ent_p1[w][TAG_W]) begin
            inv_any_p1 = 1'b1;
            inv_way_p1 = WAY_W'(w);
         end
      end
   end

   assign rsp_valid  = vld_p1;
   assign rsp_hit    = vld_p1 & hit_p1;
   assign rsp_way    = (vld_p1 && hit_p1) ? hit_way_p1 : '0;
   assign rsp_victim = !vld_p1 ? '0 : (inv_any_p1 ? inv_way_p1 : ptr_p1);
`ifdef ICACHE_TAG_PARITY_EN
   assign parity_err = vld_p1 & (|par_bad_p1);
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_icache_tag_array.sv
// Directed self-checking bench for icache_tag_array (NWAYS=2, SETS_AW=8, TAG_W=21).
// The parity scenario is compiled only when ICACHE_TAG_PARITY_EN is defined.
module tb_icache_tag_array;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [7:0]  req_index;
   logic [20:0] req_tag;
   logic        rsp_valid;
   logic        rsp_hit;
   logic [0:0]  rsp_way;
   logic [0:0]  rsp_victim;
   logic        fill_en;
   logic [7:0]  fill_index;
   logic [20:0] fill_tag;
   logic [0:0]  fill_way;
   logic        inv_req;
   logic        busy;
   logic        parity_err;

   int checks   = 0;
   int failures = 0;

   icache_tag_array dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_index  (req_index),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_hit    (rsp_hit),
      .rsp_way    (rsp_way),
      .rsp_victim (rsp_victim),
      .fill_en    (fill_en),
      .fill_index (fill_index),
      .fill_tag   (fill_tag),
      .fill_way   (fill_way),
      .inv_req    (inv_req),
      .busy       (busy),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [7:0] idx, input logic [20:0] tag);
      req_valid = 1'b1;
      req_index = idx;
      req_tag   = tag;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic fill(input logic [7:0] idx, input logic [0:0] way, input logic [20:0] tag);
      fill_en    = 1'b1;
      fill_index = idx;
      fill_way   = way;
      fill_tag   = tag;
      tick();
      fill_en = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b want=1", busy); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
      checks++; if (rsp_hit !== 1'b0 || rsp_way !== 1'b0 || rsp_victim !== 1'b0) begin
         failures++; $display("FAIL reset_rsp got hit=%0b way=%0d vic=%0d want 0/0/0", rsp_hit, rsp_way, rsp_victim); end
      checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity got=%0b want=0", parity_err); end
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checks++; if (n != 256) begin failures++; $display("FAIL reset_walk_len got=%0d want=256", n); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%0b want=1", req_ready); end
      lookup(8'h55, 21'h00001);
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_victim !== 1'b0) begin
         failures++; $display("FAIL reset_lookup got v=%0b hit=%0b vic=%0d want 1/0/0", rsp_valid, rsp_hit, rsp_victim); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_single_pulse got=%0b want=0", rsp_valid); end
   endtask

   task automatic test_fill_hit();
      fill(8'h12, 1'b1, 21'h0ABCD);
      lookup(8'h12, 21'h0ABCD);
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_way !== 1'b1) begin
         failures++; $display("FAIL fill_hit got v=%0b hit=%0b way=%0d want 1/1/1", rsp_valid, rsp_hit, rsp_way); end
      checks++; if (rsp_victim !== 1'b0) begin failures++; $display("FAIL fill_hit_victim got=%0d want=0", rsp_victim); end
      lookup(8'h12, 21'h1ABCD);
      checks++; if (rsp_hit !== 1'b0 || rsp_way !== 1'b0) begin
         failures++; $display("FAIL tag_msb_miss got hit=%0b way=%0d want 0/0", rsp_hit, rsp_way); end
      lookup(8'h13, 21'h0ABCD);
      checks++; if (rsp_hit !== 1'b0) begin failures++; $display("FAIL other_index_miss got=%0b want=0", rsp_hit); end
   endtask

   task automatic test_victim();
      fill(8'h05, 1'b0, 21'h00100);
      fill(8'h05, 1'b1, 21'h00200);
      lookup(8'h05, 21'h00300);
      checks++; if (rsp_hit !== 1'b0 || rsp_victim !== 1'b0) begin
         failures++; $display("FAIL victim_rr0 got hit=%0b vic=%0d want 0/0", rsp_hit, rsp_victim); end
      fill(8'h05, 1'b0, 21'h00101);
      lookup(8'h05, 21'h00300);
      checks++; if (rsp_hit !== 1'b0 || rsp_victim !== 1'b1) begin
         failures++; $display("FAIL victim_rr1 got hit=%0b vic=%0d want 0/1", rsp_hit, rsp_victim); end
      lookup(8'h05, 21'h00200);
      checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b1) begin
         failures++; $display("FAIL victim_set_hit1 got hit=%0b way=%0d want 1/1", rsp_hit, rsp_way); end
      fill(8'h20, 1'b1, 21'h00007);
      fill(8'h20, 1'b0, 21'h00007);
      lookup(8'h20, 21'h00007);
      checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b0) begin
         failures++; $display("FAIL dual_match_lowest got hit=%0b way=%0d want 1/0", rsp_hit, rsp_way); end
   endtask

   task automatic test_same_cycle();
      fill_en    = 1'b1;
      fill_index = 8'h07;
      fill_way   = 1'b0;
      fill_tag   = 21'h00033;
      lookup(8'h07, 21'h00033);
      fill_en = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_victim !== 1'b0) begin
         failures++; $display("FAIL same_cycle_old got v=%0b hit=%0b vic=%0d want 1/0/0", rsp_valid, rsp_hit, rsp_victim); end
      lookup(8'h07, 21'h00033);
      checks++; if (rsp_hit !== 1'b1 || rsp_way !== 1'b0 || rsp_victim !== 1'b1) begin
         failures++; $display("FAIL same_cycle_new got hit=%0b way=%0d vic=%0d want 1/0/1", rsp_hit, rsp_way, rsp_victim); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1;
      req_index = 8'h12;
      req_tag   = 21'h0ABCD;
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_way !== 1'b1) begin
         failures++; $display("FAIL b2b_first got v=%0b hit=%0b way=%0d want 1/1/1", rsp_valid, rsp_hit, rsp_way); end
      req_index = 8'h05;
      req_tag   = 21'h00101;
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_way !== 1'b0) begin
         failures++; $display("FAIL b2b_second got v=%0b hit=%0b way=%0d want 1/1/0", rsp_valid, rsp_hit, rsp_way); end
      req_valid = 1'b0;
      tick();
      checks++; if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0) begin
         failures++; $display("FAIL b2b_idle got v=%0b hit=%0b want 0/0", rsp_valid, rsp_hit); end
   endtask

`ifdef ICACHE_TAG_PARITY_EN
   task automatic test_parity();
      fill(8'h03, 1'b0, 21'h00077);
      lookup(8'h03, 21'h00077);
      checks++; if (rsp_hit !== 1'b1 || parity_err !== 1'b0) begin
         failures++; $display("FAIL parity_clean got hit=%0b perr=%0b want 1/0", rsp_hit, parity_err); end
      dut.g_way[0].mem[3][22] = ~dut.g_way[0].mem[3][22];
      lookup(8'h03, 21'h00077);
      checks++; if (rsp_hit !== 1'b0 || parity_err !== 1'b1) begin
         failures++; $display("FAIL parity_flip got hit=%0b perr=%0b want 0/1", rsp_hit, parity_err); end
   endtask
`endif

   task automatic test_invalidate();
      int n;
      int ready_seen;
      int rsp_seen;
      for (int i = 0; i < 10; i++) fill(8'h40 + 8'(i), 1'b0, 21'h00500 + 21'(i));
      lookup(8'h49, 21'h00509);
      checks++; if (rsp_hit !== 1'b1) begin failures++; $display("FAIL inv_prefill_hit got=%0b want=1", rsp_hit); end
      inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
         failures++; $display("FAIL inv_start got busy=%0b ready=%0b want 1/0", busy, req_ready); end
      n = 0; ready_seen = 0; rsp_seen = 0;
      fill_en = 1'b1; fill_index = 8'h60; fill_way = 1'b0; fill_tag = 21'h00066;
      req_valid = 1'b1; req_index = 8'h40; req_tag = 21'h00500;
      while (busy === 1'b1 && n < 400) begin
         if (req_ready !== 1'b0) ready_seen++;
         if (rsp_valid !== 1'b0) rsp_seen++;
         inv_req = (n == 100);
         tick();
         n++;
      end
      fill_en = 1'b0; req_valid = 1'b0; inv_req = 1'b0;
      checks++; if (n != 256) begin failures++; $display("FAIL inv_walk_len got=%0d want=256", n); end
      checks++; if (ready_seen != 0) begin failures++; $display("FAIL inv_ready_during_walk got=%0d want=0", ready_seen); end
      checks++; if (rsp_seen != 0 || rsp_valid !== 1'b0) begin
         failures++; $display("FAIL inv_rsp_during_walk got=%0d last=%0b want 0/0", rsp_seen, rsp_valid); end
      lookup(8'h40, 21'h00500);
      checks++; if (rsp_hit !== 1'b0 || rsp_victim !== 1'b0) begin
         failures++; $display("FAIL inv_miss_40 got hit=%0b vic=%0d want 0/0", rsp_hit, rsp_victim); end
      lookup(8'h49, 21'h00509);
      checks++; if (rsp_hit !== 1'b0) begin failures++; $display("FAIL inv_miss_49 got=%0b want=0", rsp_hit); end
      lookup(8'h60, 21'h00066);
      checks++; if (rsp_hit !== 1'b0) begin failures++; $display("FAIL inv_fill_dropped got=%0b want=0", rsp_hit); end
      lookup(8'h05, 21'h00101);
      checks++; if (rsp_hit !== 1'b0 || rsp_victim !== 1'b0) begin
         failures++; $display("FAIL inv_miss_05 got hit=%0b vic=%0d want 0/0", rsp_hit, rsp_victim); end
      lookup(8'h03, 21'h00077);
      checks++; if (rsp_hit !== 1'b0 || parity_err !== 1'b0) begin
         failures++; $display("FAIL inv_miss_03 got hit=%0b perr=%0b want 0/0", rsp_hit, parity_err); end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_index = '0; req_tag = '0;
      fill_en = 1'b0; fill_index = '0; fill_tag = '0; fill_way = '0; inv_req = 1'b0;
      test_reset();
      test_fill_hit();
      test_victim();
      test_same_cycle();
      test_back_to_back();
`ifdef ICACHE_TAG_PARITY_EN
      test_parity();
`endif
      test_invalidate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
